mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, data-memory address width (32 entries).
REQ-002 SHALL have parameter DATA_W, default 8, data-memory word width; the request/response data width is 2*DATA_W.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  pipeline presents a memory request.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_half  input  1  1 = two-byte access, 0 = single byte.
REQ-009 SHALL have port req_signed  input  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 SHALL have port req_addr  input  ADDR_W  byte address of the access.
REQ-011 SHALL have port req_wdata  input  2*DATA_W  store data; low byte first.
REQ-012 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  output  2*DATA_W  load result; 0 for stores.
REQ-014 SHALL have port mem_we  output  1  data-memory write enable.
REQ-015 SHALL have port mem_addr  output  ADDR_W  data-memory address.
REQ-016 SHALL have port mem_wdata  output  DATA_W  data-memory write data.
REQ-017 SHALL have port mem_rdata  input  DATA_W  data-memory combinational read data.

Function
REQ-018 SHALL implement FSM states IDLE, BEAT0, BEAT1, RESP.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-020 SHALL latch write, half, signed, addr and wdata on acceptance and ignore the req_* inputs until back in IDLE.
REQ-021 SHALL transition IDLE->BEAT0 on acceptance; otherwise remain in IDLE.
REQ-022 SHALL, in BEAT0, drive mem_addr = latched addr, mem_we = latched write, mem_wdata = wdata[DATA_W-1:0].
REQ-023 SHALL, in BEAT1, drive mem_addr = latched addr + 1 modulo 2^ADDR_W (31 wraps to 0), mem_we = latched write, mem_wdata = wdata[2*DATA_W-1:DATA_W].
REQ-024 SHALL transition BEAT0->BEAT1 if half, else BEAT0->RESP; BEAT1->RESP; RESP->IDLE, unconditionally.
REQ-025 SHALL, on loads, capture mem_rdata at the end of BEAT0 into the low byte and at the end of BEAT1 into the high byte.
REQ-026 SHALL, on byte loads, fill resp_rdata[2*DATA_W-1:DATA_W] with copies of bit DATA_W-1 if signed, else zeros; the signed flag is ignored for half accesses.
REQ-027 SHALL assert resp_valid for exactly the RESP cycle, with resp_rdata stable in that cycle; there is no response backpressure.
REQ-028 SHALL set resp_rdata to 0 for stores, and whenever resp_valid is 0.
REQ-029 SHALL drive mem_we = 0, mem_addr = 0 and mem_wdata = 0 in IDLE and RESP.
REQ-030 SHALL have latency, from the acceptance edge to resp_valid high, of 2 cycles for byte accesses and 3 cycles for half accesses; the next acceptance is possible 1 cycle after RESP.
REQ-031 SHALL never assert mem_we on a load.

Reset
REQ-032 SHALL, while rst is high on a rising edge, enter IDLE and clear all latched request fields and the captured load data.
REQ-033 SHALL have these output values after reset: req_ready = 1, resp_valid = 0, resp_rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-034 SHALL, when reset occurs mid-operation, abort the access with no response; a byte already written in BEAT0 remains in memory.
REQ-035 SHALL ignore a request presented in the same cycle as rst.

Verification
REQ-036 SHALL verify a byte store: addr=3, wdata=0x00A5 -> one cycle with mem_we=1, mem_addr=3, mem_wdata=0xA5; resp_valid 2 cycles after acceptance with resp_rdata=0.
REQ-037 SHALL verify a signed byte load from a location holding 0x80 -> resp_rdata=0xFF80; the same load unsigned -> 0x0080.
REQ-038 SHALL verify a half store at addr=31 with wdata=0x1234 -> writes 0x34 at 31, then 0x12 at 0; a half load at addr=31 -> resp_rdata=0x1234, resp 3 cycles after acceptance.
REQ-039 SHALL verify back-to-back req_valid held high -> req_ready low through BEAT0..RESP; the second request is accepted in the cycle after RESP; no request is lost or duplicated.
REQ-040 SHALL verify rst asserted during BEAT1 of a half store -> no resp_valid, the BEAT1 write does not occur, the byte at addr is updated and addr+1 is unchanged, outputs are at reset values.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit: serialises 1- or 2-byte loads/stores onto a byte-wide
// data memory with a combinational read port, one byte per beat.
module mem_access_unit #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic                  req_half,
   input  logic                  req_signed,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic                  resp_valid,
   output logic [2*DATA_W-1:0]   resp_rdata,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t                state;
   logic                  lat_write;
   logic                  lat_half;
   logic                  lat_signed;
   logic [ADDR_W-1:0]     lat_addr;
   logic [2*DATA_W-1:0]   lat_wdata;
   logic [DATA_W-1:0]     lo_data;
   logic                  we_q;

   // A reset landing on a write beat must stop that write at the same edge,
   // so the registered enable is masked by rst.
   assign mem_we = we_q & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lat_write  <= 1'b0;
         lat_half   <= 1'b0;
         lat_signed <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lo_data    <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         we_q       <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state      <= BEAT0;
                  lat_write  <= req_write;
                  lat_half   <= req_half;
                  lat_signed <= req_signed;
                  lat_addr   <= req_addr;
                  lat_wdata  <= req_wdata;
                  req_ready  <= 1'b0;
                  we_q       <= req_write;
                  mem_addr   <= req_addr;
                  mem_wdata  <= req_wdata[DATA_W-1:0];
               end
            end
            BEAT0: begin
               lo_data <= lat_write ? '0 : mem_rdata;
               if (lat_half) begin
                  state     <= BEAT1;
                  we_q      <= lat_write;
                  mem_addr  <= lat_addr + ADDR_ONE;
                  mem_wdata <= lat_wdata[2*DATA_W-1:DATA_W];
               end else begin
                  state      <= RESP;
                  we_q       <= 1'b0;
                  mem_addr   <= '0;
                  mem_wdata  <= '0;
                  resp_valid <= 1'b1;
                  if (lat_write)
                     resp_rdata <= '0;
                  else
                     resp_rdata <= {{DATA_W{lat_signed & mem_rdata[DATA_W-1]}}, mem_rdata};
               end
            end
            BEAT1: begin
               state      <= RESP;
               we_q       <= 1'b0;
               mem_addr   <= '0;
               mem_wdata  <= '0;
               resp_valid <= 1'b1;
               resp_rdata <= lat_write ? '0 : {mem_rdata, lo_data};
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               resp_rdata <= '0;
               req_ready  <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, multi-cycle corner cases,
// then random traffic checked against an array-based reference memory.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_half;
   logic        req_signed;
   logic [4:0]  req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        mem_we;
   logic [4:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   logic [7:0]  tmem [32] = '{default: 8'h00};
   int          ref_mem [32] = '{default: 0};
   int          nerr = 0;
   int          nchk = 0;

   mem_access_unit #(.ADDR_W(5), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_half(req_half), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = tmem[mem_addr];
   always @(posedge clk) if (mem_we) tmem[mem_addr] <= mem_wdata;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: byte-addressed memory, little-endian halves, wrap at 32.
   function automatic logic [15:0] model(input logic w, input logic h, input logic s,
                                         input logic [4:0] a, input logic [15:0] wd);
      int a0 = int'(a);
      int a1 = (a0 + 1) % 32;
      int v;
      if (w) begin
         ref_mem[a0] = int'(wd) % 256;
         if (h) ref_mem[a1] = int'(wd) / 256;
         return 16'h0;
      end
      if (h) v = ref_mem[a1] * 256 + ref_mem[a0];
      else if (s && ref_mem[a0] >= 128) v = ref_mem[a0] - 256 + 65536;
      else v = ref_mem[a0];
      return 16'(v);
   endfunction

   // Runs one request from an IDLE-aligned point (#1 after an edge).
   task automatic do_txn(input logic w, input logic h, input logic s,
                         input logic [4:0] a, input logic [15:0] wd,
                         output logic [15:0] rd, output int lat, output int nwr);
      int waitc = 0;
      req_write = w; req_half = h; req_signed = s; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      while (!req_ready && waitc < 10) begin tick(); waitc++; end
      if (!req_ready) check("ready_timeout", 0, 1);
      tick();
      req_valid = 1'b0;
      req_write = 1'($urandom); req_half = 1'($urandom); req_signed = 1'($urandom);
      req_addr = 5'($urandom); req_wdata = 16'($urandom);
      lat = 1; nwr = 0;
      while (!resp_valid && lat < 8) begin
         if (mem_we) begin
            check("wr_addr", 32'(mem_addr), 32'(5'(a + 5'(nwr))));
            check("wr_data", 32'(mem_wdata), 32'((nwr == 0) ? wd[7:0] : wd[15:8]));
            nwr++;
         end
         tick();
         lat++;
      end
      if (!resp_valid) check("resp_timeout", 0, 1);
      rd = resp_rdata;
      check("resp_mem_idle", {mem_we, 3'b0, mem_addr, mem_wdata}, 32'h0);
      tick();
      check("resp_one_cycle", {resp_valid, req_ready}, 32'h1);
      check("rdata_cleared", 32'(resp_rdata), 32'h0);
   endtask

   typedef struct {
      logic        w, h, s;
      logic [4:0]  a;
      logic [15:0] wd;
      logic [15:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [15:0] rd, expd;
      logic [7:0]  acc_bits, rdy_bits, rsp_bits;
      logic [15:0] rsp_data [2];
      int          lat, nwr, nacc, nrsp, bad;
      logic        acc_prev;
      int          old9;
      logic        w, h, s;
      logic [4:0]  a;
      logic [15:0] wd;

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'd3,  16'h00A5, 16'h0000, 2};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'd10, 16'h3380, 16'h0000, 2};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 5'd10, 16'h0000, 16'hFF80, 2};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 5'd10, 16'h0000, 16'h0080, 2};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 5'd31, 16'h1234, 16'h0000, 3};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 5'd31, 16'h0000, 16'h1234, 3};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 5'd3,  16'h0000, 16'hFFA5, 2};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 5'd0,  16'h0000, 16'h0012, 2};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 5'd3,  16'h0000, 16'h00A5, 3};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 5'd4,  16'hFF7F, 16'h0000, 2};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 5'd3,  16'h0000, 16'h7FA5, 3};

      // Reset with a request pending: the request must be dropped.
      rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_half = 1'b0;
      req_signed = 1'b0; req_addr = 5'd5; req_wdata = 16'h00FF;
      tick(); tick();
      check("rst_outputs", {req_ready, resp_valid, resp_rdata, mem_we, mem_addr, mem_wdata},
            {1'b1, 1'b0, 16'h0, 1'b0, 5'h0, 8'h0});
      rst = 1'b0; req_valid = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (!req_ready || resp_valid || mem_we) bad++;
         tick();
      end
      check("rst_req_ignored", bad, 0);
      check("rst_no_write", 32'(tmem[5]), 32'h0);

      for (int i = 0; i < 11; i++) begin
         do_txn(tbl[i].w, tbl[i].h, tbl[i].s, tbl[i].a, tbl[i].wd, rd, lat, nwr);
         expd = model(tbl[i].w, tbl[i].h, tbl[i].s, tbl[i].a, tbl[i].wd);
         check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tbl[i].exp));
         check($sformatf("vec%0d_model", i), 32'(rd), 32'(expd));
         check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
         check($sformatf("vec%0d_nwr", i), nwr, tbl[i].w ? (tbl[i].h ? 2 : 1) : 0);
      end
      check("half_wrap_31", 32'(tmem[31]), 32'h34);
      check("half_wrap_0", 32'(tmem[0]), 32'h12);

      // req_valid held high across two requests.
      req_write = 1'b0; req_half = 1'b0; req_signed = 1'b0; req_addr = 5'd3;
      req_wdata = 16'h0; req_valid = 1'b1;
      acc_bits = '0; rdy_bits = '0; rsp_bits = '0; nacc = 0; nrsp = 0;
      rsp_data[0] = '0; rsp_data[1] = '0;
      for (int c = 0; c < 8; c++) begin
         rdy_bits[c] = req_ready;
         acc_prev = req_valid & req_ready;
         acc_bits[c] = acc_prev;
         if (resp_valid) begin
            rsp_bits[c] = 1'b1;
            if (nrsp < 2) rsp_data[nrsp] = resp_rdata;
            nrsp++;
         end
         tick();
         if (acc_prev) begin
            nacc++;
            if (nacc == 1) begin req_addr = 5'd10; req_signed = 1'b1; end
            else req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      check("b2b_ready", 32'(rdy_bits), 32'hC9);
      check("b2b_accept", 32'(acc_bits), 32'h09);
      check("b2b_resp", 32'(rsp_bits), 32'h24);
      check("b2b_data0", 32'(rsp_data[0]), 32'h00A5);
      check("b2b_data1", 32'(rsp_data[1]), 32'hFF80);

      // Reset during BEAT1 of a half store at 8.
      old9 = ref_mem[9];
      req_write = 1'b1; req_half = 1'b1; req_signed = 1'b0; req_addr = 5'd8;
      req_wdata = 16'hBEEF; req_valid = 1'b1;
      check("ab_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 1'b0;
      check("ab_beat0", {mem_we, mem_addr, mem_wdata}, {1'b1, 5'd8, 8'hEF});
      tick();
      check("ab_beat1", {mem_we, mem_addr, mem_wdata}, {1'b1, 5'd9, 8'hBE});
      rst = 1'b1;
      #1;
      check("ab_we_masked", 32'(mem_we), 32'h0);
      tick();
      rst = 1'b0;
      check("ab_outputs", {req_ready, resp_valid, resp_rdata, mem_we, mem_addr, mem_wdata},
            {1'b1, 1'b0, 16'h0, 1'b0, 5'h0, 8'h0});
      check("ab_byte8", 32'(tmem[8]), 32'hEF);
      check("ab_byte9", 32'(tmem[9]), 32'(old9));
      ref_mem[8] = 32'hEF;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (resp_valid || mem_we) bad++;
         tick();
      end
      check("ab_no_resp", bad, 0);

      // Random traffic against the reference memory.
      for (int i = 0; i < 200; i++) begin
         w = 1'($urandom); h = 1'($urandom); s = 1'($urandom);
         a = 5'($urandom); wd = 16'($urandom);
         do_txn(w, h, s, a, wd, rd, lat, nwr);
         expd = model(w, h, s, a, wd);
         check("rnd_rdata", 32'(rd), 32'(expd));
         check("rnd_lat", lat, h ? 3 : 2);
         check("rnd_nwr", nwr, w ? (h ? 2 : 1) : 0);
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end
      bad = 0;
      for (int i = 0; i < 32; i++) if (int'(tmem[i]) != ref_mem[i]) bad++;
      check("mem_image", bad, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
